// File: rtl/game_board_mem.sv
// game_board_mem: 8x8 board storage (2 bits per cell) with a one-cycle read
// responder for the judger, stone-placement writes from the game controller,
// and a 64-cycle clear sweep.
// Optional feature: define BOARD_STONE_COUNT_EN to get live red/green stone
// counters. Without it, red_count/green_count are tied to zero.
module game_board_mem #(
  parameter logic [1:0] CLEAR_VALUE = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_en,
  input  logic [5:0] mem_addr,
  output logic       mem_valid,
  output logic [1:0] mem_data,
  input  logic       wr_en,
  input  logic [5:0] wr_pos,
  input  logic       wr_color,
  output logic       wr_done,
  output logic       wr_err,
  input  logic       clr,
  output logic       busy,
  output logic [6:0] red_count,
  output logic [6:0] green_count
);

  // Side encoding shared with the game controller (common.vh).
  localparam logic SIDE_RED   = 1'b1;
  localparam logic SIDE_GREEN = 1'b0;

  typedef enum logic {
    S_READY = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t     state;
  logic [5:0] clr_cnt;
  logic [1:0] cells [64];
  logic       wr_ok;

  // A write lands only on an empty cell while idle and not racing a clear.
  always_comb begin
    wr_ok = wr_en && (state == S_READY) && !clr && (cells[wr_pos] == 2'b00);
  end

  assign busy = (state == S_CLEAR);

  // Board state, clear sweep, read responder and write acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells     <= '{default: CLEAR_VALUE};
      state     <= S_READY;
      clr_cnt   <= '0;
      mem_valid <= 1'b0;
      mem_data  <= '0;
      wr_done   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      // Reads sample the pre-write cell value; a pending valid always drops.
      if (mem_valid) begin
        mem_valid <= 1'b0;
      end else if (mem_en && (state == S_READY)) begin
        mem_data  <= cells[mem_addr];
        mem_valid <= 1'b1;
      end

      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      if (wr_en) begin
        if (wr_ok) begin
          cells[wr_pos] <= (wr_color == SIDE_RED) ? 2'b10 : 2'b01;
          wr_done       <= 1'b1;
        end else begin
          wr_err <= 1'b1;
        end
      end

      case (state)
        S_READY: begin
          if (clr) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
        S_CLEAR: begin
          cells[clr_cnt] <= CLEAR_VALUE;
          clr_cnt        <= clr_cnt + 6'd1;
          if (clr_cnt == 6'd63) begin
            state <= S_READY;
          end
        end
        default: state <= S_READY;
      endcase
    end
  end

`ifdef BOARD_STONE_COUNT_EN
  // Stone counters follow accepted writes; an accepted clear zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_count   <= '0;
      green_count <= '0;
    end else if (clr && (state == S_READY)) begin
      red_count   <= '0;
      green_count <= '0;
    end else if (wr_ok) begin
      if (wr_color == SIDE_RED) begin
        red_count <= red_count + 7'd1;
      end else begin
        green_count <= green_count + 7'd1;
      end
    end
  end
`else
  assign red_count   = 7'd0;
  assign green_count = 7'd0;
  // SIDE_GREEN is only meaningful to the counter path.
  logic unused_side;
  assign unused_side = SIDE_GREEN;
`endif

endmodule

// File: tb/tb_game_board_mem.sv
// tb_game_board_mem: directed test-plan sequences plus randomized traffic,
// every cycle checked against a behavioural board model.
module tb_game_board_mem;

  localparam logic RED   = 1'b1;
  localparam logic GREEN = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_en = 1'b0;
  logic [5:0] mem_addr = '0;
  logic       mem_valid;
  logic [1:0] mem_data;
  logic       wr_en = 1'b0;
  logic [5:0] wr_pos = '0;
  logic       wr_color = 1'b0;
  logic       wr_done;
  logic       wr_err;
  logic       clr = 1'b0;
  logic       busy;
  logic [6:0] red_count;
  logic [6:0] green_count;

  int checks = 0;
  int failures = 0;

  // Behavioural model: board contents, remaining clear cycles, outputs.
  int m_cell [64];
  int m_busy_left;
  int m_valid, m_data, m_done, m_err, m_red, m_green;

  always #5 clk = ~clk;

  game_board_mem #(.CLEAR_VALUE(2'b00)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .wr_en(wr_en), .wr_pos(wr_pos), .wr_color(wr_color),
    .wr_done(wr_done), .wr_err(wr_err),
    .clr(clr), .busy(busy),
    .red_count(red_count), .green_count(green_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cell[i] = 0;
    m_busy_left = 0;
    m_valid = 0; m_data = 0; m_done = 0; m_err = 0; m_red = 0; m_green = 0;
  endtask

  task automatic check_all();
    check("mem_valid", mem_valid, m_valid);
    check("mem_data", mem_data, m_data);
    check("wr_done", wr_done, m_done);
    check("wr_err", wr_err, m_err);
    check("busy", busy, m_busy_left > 0);
`ifdef BOARD_STONE_COUNT_EN
    check("red_count", red_count, m_red);
    check("green_count", green_count, m_green);
`else
    check("red_count", red_count, 0);
    check("green_count", green_count, 0);
`endif
  endtask

  // One clock: drive inputs, step the model at the edge, check just after.
  task automatic cycle(input logic en, input logic [5:0] addr, input logic we,
                       input logic [5:0] pos, input logic col, input logic c);
    bit idle;
    @(negedge clk);
    mem_en = en; mem_addr = addr; wr_en = we; wr_pos = pos; wr_color = col; clr = c;
    @(posedge clk);
    idle = (m_busy_left == 0);
    if (m_valid) m_valid = 0;
    else if (en && idle) begin
      m_valid = 1;
      m_data = m_cell[addr];
    end
    m_done = 0; m_err = 0;
    if (we) begin
      if (idle && !c && m_cell[pos] == 0) begin
        m_cell[pos] = (col == RED) ? 2 : 1;
        m_done = 1;
        if (col == RED) m_red++; else m_green++;
      end else m_err = 1;
    end
    if (!idle) m_busy_left--;
    else if (c) begin
      // The sweep is unobservable while busy, so the model clears at once.
      for (int i = 0; i < 64; i++) m_cell[i] = 0;
      m_busy_left = 64;
      m_red = 0; m_green = 0;
    end
    #1;
    check_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  int busy_cycles;

  initial begin
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;

    // Read after reset.
    cycle(1, 6'h12, 0, 0, 0, 0);
    check("rst_read_data", mem_data, 2'b00);
    check("rst_read_valid", mem_valid, 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("rst_read_drop", mem_valid, 0);

    // Red write, read back, then a rejected green write.
    cycle(0, 0, 1, 6'h12, RED, 0);
    check("red_done", wr_done, 1);
    cycle(1, 6'h12, 0, 0, 0, 0);
    check("red_read", mem_data, 2'b10);
    cycle(0, 0, 1, 6'h12, GREEN, 0);
    check("occupied_err", wr_err, 1);
    cycle(1, 6'h12, 0, 0, 0, 0);
    check("still_red", mem_data, 2'b10);
    cycle(0, 0, 0, 0, 0, 0);

    // mem_en held high: response every other cycle.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 6'h00, 0, 0, 0, 0);
      check("hold_toggle", mem_valid, (i % 2 == 0) ? 1 : 0);
    end

    // Same-edge write and read.
    cycle(1, 6'h2D, 1, 6'h2D, GREEN, 0);
    check("same_edge_pre", mem_data, 2'b00);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 6'h2D, 0, 0, 0, 0);
    check("same_edge_post", mem_data, 2'b01);

    // A few more stones so counters reach 3 red / 2 green.
    cycle(0, 0, 1, 6'h01, RED, 0);
    cycle(0, 0, 1, 6'h3F, RED, 0);
    cycle(0, 0, 1, 6'h20, GREEN, 0);
`ifdef BOARD_STONE_COUNT_EN
    check("red_eq3", red_count, 3);
    check("green_eq2", green_count, 2);
`endif

    // Clear with mem_en held; write during busy must fail.
    busy_cycles = 0;
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 70 && busy; i++) begin
      busy_cycles++;
      check("no_valid_busy", mem_valid, 0);
      cycle(1, 6'h12, (i == 5), 6'h05, RED, 0);
    end
    check("busy_len", busy_cycles, 64);
    while (!mem_valid && busy_cycles < 80) begin
      busy_cycles++;
      cycle(1, 6'h12, 0, 0, 0, 0);
    end
    check("post_clear_read", mem_data, 2'b00);
    idle_cycles(2);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] a, p;
      a = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      p = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      cycle($urandom_range(0, 1) != 0, a, $urandom_range(0, 2) == 0, p,
            $urandom_range(0, 1) != 0, $urandom_range(0, 199) == 0);
    end

    // Asynchronous reset in the middle of a sweep.
    cycle(0, 0, 1, 6'h07, RED, 0);
    idle_cycles(70);
    cycle(0, 0, 1, 6'h08, GREEN, 0);
    cycle(0, 0, 0, 0, 0, 1);
    idle_cycles(10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_busy", busy, 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 6'h07, 0, 0, 0, 0);
    check("rst_mid_cell", mem_data, 2'b00);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
